// File: rtl/control.sv
// Main decode unit for the MIPS subset: opcode/funct in, registered datapath
// control strobes and ALU operation code out (one cycle of latency).
module control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       ALUSrc,
  output logic       RegDst,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       Beq,
  output logic       Bne,
  output logic       Jump,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic [2:0] ALUControl
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic       alusrc_s, regdst_s, memwrite_s, memread_s;
  logic       beq_s, bne_s, jump_s, memtoreg_s, regwrite_s;
  logic [2:0] aluctl_s;

  logic       alusrc_r, regdst_r, memwrite_r, memread_r;
  logic       beq_r, bne_r, jump_r, memtoreg_r, regwrite_r;
  logic [2:0] aluctl_r;

  // Combinational decode; unknown opcodes/functs fall back to a side-effect-free ADD.
  always_comb begin
    alusrc_s   = 1'b0;
    regdst_s   = 1'b0;
    memwrite_s = 1'b0;
    memread_s  = 1'b0;
    beq_s      = 1'b0;
    bne_s      = 1'b0;
    jump_s     = 1'b0;
    memtoreg_s = 1'b0;
    regwrite_s = 1'b0;
    aluctl_s   = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
        case (funct)
          FN_ADD:  aluctl_s = ALU_ADD;
          FN_SUB:  aluctl_s = ALU_SUB;
          FN_AND:  aluctl_s = ALU_AND;
          FN_OR:   aluctl_s = ALU_OR;
          FN_SLT:  aluctl_s = ALU_SLT;
          default: begin
            regdst_s   = 1'b0;
            regwrite_s = 1'b0;
            aluctl_s   = ALU_ADD;
          end
        endcase
      end
      OP_LW: begin
        alusrc_s   = 1'b1;
        memread_s  = 1'b1;
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      OP_SW: begin
        alusrc_s   = 1'b1;
        memwrite_s = 1'b1;
      end
      OP_BEQ: begin
        beq_s    = 1'b1;
        aluctl_s = ALU_SUB;
      end
      OP_BNE: begin
        bne_s    = 1'b1;
        aluctl_s = ALU_SUB;
      end
      OP_J: begin
        jump_s = 1'b1;
      end
      default: begin
        aluctl_s = ALU_ADD;
      end
    endcase
  end

  // Output registers: capture the decode each edge, clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alusrc_r   <= 1'b0;
      regdst_r   <= 1'b0;
      memwrite_r <= 1'b0;
      memread_r  <= 1'b0;
      beq_r      <= 1'b0;
      bne_r      <= 1'b0;
      jump_r     <= 1'b0;
      memtoreg_r <= 1'b0;
      regwrite_r <= 1'b0;
      aluctl_r   <= 3'b000;
    end else begin
      alusrc_r   <= alusrc_s;
      regdst_r   <= regdst_s;
      memwrite_r <= memwrite_s;
      memread_r  <= memread_s;
      beq_r      <= beq_s;
      bne_r      <= bne_s;
      jump_r     <= jump_s;
      memtoreg_r <= memtoreg_s;
      regwrite_r <= regwrite_s;
      aluctl_r   <= aluctl_s;
    end
  end

  assign ALUSrc     = alusrc_r;
  assign RegDst     = regdst_r;
  assign MemWrite   = memwrite_r;
  assign MemRead    = memread_r;
  assign Beq        = beq_r;
  assign Bne        = bne_r;
  assign Jump       = jump_r;
  assign MemToReg   = memtoreg_r;
  assign RegWrite   = regwrite_r;
  assign ALUControl = aluctl_r;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: table-driven decode model, per-cycle compare
// at the falling edge, directed literal checks plus randomized traffic.
module tb_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ALUSrc, RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite;
  logic [2:0] ALUControl;

  int tests_run = 0;
  int tests_failed = 0;

  control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .ALUSrc(ALUSrc), .RegDst(RegDst), .MemWrite(MemWrite), .MemRead(MemRead),
    .Beq(Beq), .Bne(Bne), .Jump(Jump), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ALUControl(ALUControl)
  );

  // Packed view: {ALUSrc,RegDst,MemWrite,MemRead,Beq,Bne,Jump,MemToReg,RegWrite,ALUControl}
  logic [11:0] dut_vec;
  assign dut_vec = {ALUSrc, RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite, ALUControl};

  localparam logic [11:0] V_LW   = 12'b100100011010;
  localparam logic [11:0] V_SW   = 12'b101000000010;
  localparam logic [11:0] V_ADD  = 12'b010000001010;
  localparam logic [11:0] V_SUB  = 12'b010000001110;
  localparam logic [11:0] V_AND  = 12'b010000001000;
  localparam logic [11:0] V_OR   = 12'b010000001001;
  localparam logic [11:0] V_SLT  = 12'b010000001111;
  localparam logic [11:0] V_BEQ  = 12'b000010000110;
  localparam logic [11:0] V_BNE  = 12'b000001000110;
  localparam logic [11:0] V_J    = 12'b000000100010;
  localparam logic [11:0] V_NOP  = 12'b000000000010;
  localparam logic [11:0] V_ZERO = 12'b000000000000;

  // Reference decode: lookup tables of legal encodings, everything else is a NOP.
  logic [5:0]  op_tab  [5] = '{6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010};
  logic [11:0] op_word [5] = '{V_LW, V_SW, V_BEQ, V_BNE, V_J};
  logic [5:0]  fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [11:0] fn_word [5] = '{V_ADD, V_SUB, V_AND, V_OR, V_SLT};

  function automatic logic [11:0] model(input logic [5:0] op, input logic [5:0] fn);
    logic [11:0] w;
    w = V_NOP;
    if (op == 6'b000000) begin
      for (int i = 0; i < 5; i++) if (fn_tab[i] == fn) w = fn_word[i];
    end else begin
      for (int i = 0; i < 5; i++) if (op_tab[i] == op) w = op_word[i];
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs: registered view of the reference decode.
  logic [11:0] exp_vec;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_vec <= V_ZERO;
    else        exp_vec <= model(opcode, funct);
  end

  // Every-cycle compare away from the active edge.
  always @(negedge clk) check("cycle", dut_vec, exp_vec);

  task automatic drive(input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk); #1;
    opcode = op;
    funct  = fn;
  endtask

  task automatic expect_after_edge(input string name, input logic [11:0] exp);
    @(posedge clk); #1;
    check(name, dut_vec, exp);
  endtask

  logic [11:0] held;
  logic [5:0]  op_pool [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b111111};

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b100011;
    funct  = 6'b000000;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", dut_vec, V_ZERO);
    check("model_lw", model(6'b100011, 6'b111111), V_LW);
    check("model_slt", model(6'b000000, 6'b101010), V_SLT);
    check("model_badfn", model(6'b000000, 6'b000111), V_NOP);

    @(negedge clk); #1 rst_n = 1'b1;
    expect_after_edge("reset_release_lw", V_LW);

    drive(6'b000000, 6'b100000); expect_after_edge("r_add", V_ADD);
    drive(6'b000000, 6'b100010); expect_after_edge("r_sub", V_SUB);
    drive(6'b000000, 6'b100100); expect_after_edge("r_and", V_AND);
    drive(6'b000000, 6'b100101); expect_after_edge("r_or",  V_OR);
    drive(6'b000000, 6'b101010); expect_after_edge("r_slt", V_SLT);
    drive(6'b101011, 6'b100000); expect_after_edge("sw", V_SW);
    drive(6'b000100, 6'b000000); expect_after_edge("beq", V_BEQ);
    drive(6'b000101, 6'b000000); expect_after_edge("bne", V_BNE);
    drive(6'b000010, 6'b000000); expect_after_edge("jump", V_J);
    drive(6'b000000, 6'b000111); expect_after_edge("bad_funct", V_NOP);
    drive(6'b111111, 6'b100000); expect_after_edge("bad_opcode", V_NOP);
    drive(6'b100011, 6'b100010); expect_after_edge("lw_fn_a", V_LW);
    drive(6'b100011, 6'b101010); expect_after_edge("lw_fn_b", V_LW);

    // Mid-cycle input change must not reach outputs before the next edge.
    @(posedge clk); #2;
    opcode = 6'b000100;
    #2 check("hold_midcycle", dut_vec, V_LW);
    expect_after_edge("after_change", V_BEQ);

    // Asynchronous clear between edges.
    #1 rst_n = 1'b0;
    #1 check("async_clear", dut_vec, V_ZERO);
    @(negedge clk); #1 rst_n = 1'b1;
    drive(6'b000010, 6'b000000);
    expect_after_edge("post_async_jump", V_J);

    // Randomized traffic, occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); #1;
      rst_n  = ($urandom_range(0, 39) != 0);
      opcode = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 6)];
      funct  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
    end
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
